// File: rtl/matrix_outer_product_2x1_1x2.sv
// 2x2 outer product C = d * x of a 2x1 column and a 1x2 row vector, computed one
// element per cycle on a single shared floating-point multiplier.

module mop_fp_mul #(
  parameter int exp_width  = 8,
  parameter int mant_width = 24
) (
  input  logic [exp_width+mant_width-1:0] a,
  input  logic [exp_width+mant_width-1:0] b,
  input  logic [2:0]                      round_mode,
  output logic [exp_width+mant_width-1:0] y,
  output logic [4:0]                      exc
);
  // Round modes: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM (others RNE); flags {NV, DZ, OF, UF, NX}.
  // Subnormal inputs are treated as zero and tiny results flush to signed zero.
  localparam int frac_w = mant_width - 1;
  localparam int w      = exp_width + mant_width;
  localparam logic [exp_width+1:0] bias_e = (exp_width+2)'((1 << (exp_width - 1)) - 1);
  localparam logic [exp_width+1:0] ovf_e  = bias_e + (exp_width+2)'((1 << exp_width) - 1);

  logic                      sign;
  logic [exp_width-1:0]      ea, eb;
  logic [frac_w-1:0]         fa, fb;
  logic                      a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  logic [2*mant_width-1:0]   prod, norm;
  logic [mant_width-1:0]     keep;
  logic                      guard, sticky, inc, carry, to_max;
  logic [frac_w-1:0]         frac_rnd;
  logic [exp_width+1:0]      e_sum;

  assign sign   = a[w-1] ^ b[w-1];
  assign ea     = a[w-2:frac_w];
  assign eb     = b[w-2:frac_w];
  assign fa     = a[frac_w-1:0];
  assign fb     = b[frac_w-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);
  assign a_snan = a_nan && !fa[frac_w-1];
  assign b_snan = b_nan && !fb[frac_w-1];

  assign prod     = (2*mant_width)'({1'b1, fa}) * (2*mant_width)'({1'b1, fb});
  assign norm     = prod[2*mant_width-1] ? prod : {prod[2*mant_width-2:0], 1'b0};
  assign keep     = norm[2*mant_width-1:mant_width];
  assign guard    = norm[mant_width-1];
  assign sticky   = |norm[mant_width-2:0];
  assign carry    = (&keep) & inc;
  assign frac_rnd = keep[frac_w-1:0] + frac_w'(inc);
  assign e_sum    = {2'b00, ea} + {2'b00, eb} + (exp_width+2)'(prod[2*mant_width-1])
                  + (exp_width+2)'(carry);
  assign to_max   = (round_mode == 3'd1) || ((round_mode == 3'd2) && !sign)
                  || ((round_mode == 3'd3) && sign);

  // Rounding increment decision
  always_comb begin
    inc = 1'b0;
    case (round_mode)
      3'd0:    inc = guard & (sticky | keep[0]);
      3'd1:    inc = 1'b0;
      3'd2:    inc = sign & (guard | sticky);
      3'd3:    inc = ~sign & (guard | sticky);
      3'd4:    inc = guard;
      default: inc = guard & (sticky | keep[0]);
    endcase
  end

  // Result and exception selection
  always_comb begin
    y   = '0;
    exc = 5'b00000;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      y      = {1'b0, {exp_width{1'b1}}, 1'b1, {(frac_w-1){1'b0}}};
      exc[4] = (a_inf && b_zero) || (b_inf && a_zero) || a_snan || b_snan;
    end else if (a_inf || b_inf) begin
      y = {sign, {exp_width{1'b1}}, {frac_w{1'b0}}};
    end else if (a_zero || b_zero) begin
      y = {sign, {(w-1){1'b0}}};
    end else if (e_sum >= ovf_e) begin
      exc = 5'b00101;
      if (to_max) y = {sign, {(exp_width-1){1'b1}}, 1'b0, {frac_w{1'b1}}};
      else        y = {sign, {exp_width{1'b1}}, {frac_w{1'b0}}};
    end else if (e_sum <= bias_e) begin
      exc = 5'b00011;
      y   = {sign, {(w-1){1'b0}}};
    end else begin
      y      = {sign, exp_width'(e_sum - bias_e), frac_rnd};
      exc[0] = guard | sticky;
    end
  end
endmodule

module matrix_outer_product_2x1_1x2 #(
  parameter int exp_width  = 8,
  parameter int mant_width = 24
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [exp_width+mant_width-1:0] d1,
  input  logic [exp_width+mant_width-1:0] d2,
  input  logic [exp_width+mant_width-1:0] x1,
  input  logic [exp_width+mant_width-1:0] x2,
  input  logic [2:0]                      round_mode,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [exp_width+mant_width-1:0] c11,
  output logic [exp_width+mant_width-1:0] c12,
  output logic [exp_width+mant_width-1:0] c21,
  output logic [exp_width+mant_width-1:0] c22,
  output logic [4:0]                      exceptions
);
  localparam int w = exp_width + mant_width;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

  state_t       state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  logic [w-1:0] d1_q, d1_d, d2_q, d2_d, x1_q, x1_d, x2_q, x2_d;
  logic [2:0]   rm_q, rm_d;
  logic [w-1:0] c11_q, c11_d, c12_q, c12_d, c21_q, c21_d, c22_q, c22_d;
  logic [4:0]   exc_q, exc_d;
  logic         in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [w-1:0] mul_a, mul_b, mul_y;
  logic [4:0]   mul_exc;

  // idx bit 1 picks the d row, bit 0 the x column
  assign mul_a = idx_q[1] ? d2_q : d1_q;
  assign mul_b = idx_q[0] ? x2_q : x1_q;

  mop_fp_mul #(.exp_width(exp_width), .mant_width(mant_width)) u_mul (
    .a(mul_a), .b(mul_b), .round_mode(rm_q), .y(mul_y), .exc(mul_exc)
  );

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    rm_d        = rm_q;
    c11_d       = c11_q;
    c12_d       = c12_q;
    c21_d       = c21_q;
    c22_d       = c22_q;
    exc_d       = exc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          d1_d       = d1;
          d2_d       = d2;
          x1_d       = x1;
          x2_d       = x2;
          rm_d       = round_mode;
          exc_d      = 5'b00000;
          idx_d      = 2'd0;
          state_d    = MUL;
          in_ready_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        case (idx_q)
          2'd0:    c11_d = mul_y;
          2'd1:    c12_d = mul_y;
          2'd2:    c21_d = mul_y;
          default: c22_d = mul_y;
        endcase
        exc_d = exc_q | mul_exc;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          state_d = MUL;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      d1_q        <= '0;
      d2_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      rm_q        <= 3'd0;
      c11_q       <= '0;
      c12_q       <= '0;
      c21_q       <= '0;
      c22_q       <= '0;
      exc_q       <= 5'b00000;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      rm_q        <= rm_d;
      c11_q       <= c11_d;
      c12_q       <= c12_d;
      c21_q       <= c21_d;
      c22_q       <= c22_d;
      exc_q       <= exc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign c11        = c11_q;
  assign c12        = c12_q;
  assign c21        = c21_q;
  assign c22        = c22_q;
  assign exceptions = exc_q;
endmodule

// File: tb/tb_matrix_outer_product_2x1_1x2.sv
// Scoreboard bench for the 2x2 outer-product block: stimulus pushes expected matrices,
// a monitor pops and compares them on every output handshake.

module tb_matrix_outer_product_2x1_1x2;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] d1 = 32'h0, d2 = 32'h0, x1 = 32'h0, x2 = 32'h0;
  logic [2:0]  round_mode = 3'd0;
  logic [31:0] c11, c12, c21, c22;
  logic [4:0]  exceptions;

  typedef struct packed {
    logic [31:0] c11, c12, c21, c22;
    logic [4:0]  exc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  matrix_outer_product_2x1_1x2 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .d1(d1), .d2(d2), .x1(x1), .x2(x2), .round_mode(round_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22), .exceptions(exceptions)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Monitor: the edge after a negedge with out_valid && out_ready is the handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got c11=%h, want no result", c11);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("c11", c11, e.c11);
        chk("c12", c12, e.c12);
        chk("c21", c21, e.c21);
        chk("c22", c22, e.c22);
        chk("exceptions", {27'd0, exceptions}, {27'd0, e.exc});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [31:0] a1, input logic [31:0] a2,
                         input logic [31:0] b1, input logic [31:0] b2);
    d1 = a1; d2 = a2; x1 = b1; x2 = b2;
  endtask

  task automatic wait_in_ready();
    int n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL in_ready_timeout: got 0, want 1 within 50 cycles");
    end
  endtask

  task automatic wait_out_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin step(); lat++; end
    if (!out_valid) begin
      total++; bad++;
      $display("FAIL out_valid_timeout: got 0, want 1 within 50 cycles");
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (out_valid && n < 50) begin step(); n++; end
  endtask

  // Present operands, hold in_valid through the accept edge, return just after it
  task automatic accept(input logic [31:0] a1, input logic [31:0] a2,
                        input logic [31:0] b1, input logic [31:0] b2);
    set_ops(a1, a2, b1, b2);
    in_valid = 1'b1;
    wait_in_ready();
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [31:0] a1, input logic [31:0] a2,
                        input logic [31:0] b1, input logic [31:0] b2, input exp_t e);
    int lat;
    sb_q.push_back(e);
    accept(a1, a2, b1, b2);
    wait_out_valid(lat);
    chk({name, "_latency"}, lat, 32'd4);
    wait_done();
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_c11"}, c11, 32'h0);
    chk({tag, "_c12"}, c12, 32'h0);
    chk({tag, "_c21"}, c21, 32'h0);
    chk({tag, "_c22"}, c22, 32'h0);
    chk({tag, "_exceptions"}, {27'd0, exceptions}, 32'd0);
  endtask

  // Hand-computed expectations
  localparam exp_t EXP_A = '{c11: 32'h41000000, c12: 32'hC0000000, c21: 32'h41400000,
                             c22: 32'hC0400000, exc: 5'h00};
  localparam exp_t EXP_B = '{c11: 32'h40400000, c12: 32'h3F400000, c21: 32'hC0800000,
                             c22: 32'hBF800000, exc: 5'h00};
  localparam exp_t EXP_C = '{c11: 32'hC0400000, c12: 32'h41000000, c21: 32'h3F400000,
                             c22: 32'hC0000000, exc: 5'h00};
  localparam exp_t EXP_CHG = '{c11: 32'h3F800000, c12: 32'h3F800000, c21: 32'h3F000000,
                               c22: 32'h3F000000, exc: 5'h00};
  localparam exp_t EXP_OVF = '{c11: 32'h7F800000, c12: 32'h7F000000, c21: 32'h7F000000,
                               c22: 32'h3F800000, exc: 5'h05};

  initial begin
    int lat;
    int acc[3];
    int n;

    repeat (3) step();
    rst_n = 1'b1;
    check_idle_zero("reset");
    out_ready = 1'b1;

    // Basic operation
    run_op("basic", 32'h40000000, 32'h40400000, 32'h40800000, 32'hBF800000, EXP_A);

    // Backpressure: result held 10 cycles while a second request waits
    out_ready = 1'b0;
    sb_q.push_back(EXP_B);
    accept(32'h3FC00000, 32'hC0000000, 32'h40000000, 32'h3F000000);
    wait_out_valid(lat);
    chk("bp_latency", lat, 32'd4);
    sb_q.push_back(EXP_A);
    set_ops(32'h40000000, 32'h40400000, 32'h40800000, 32'hBF800000);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_c11_hold", c11, EXP_B.c11);
      chk("bp_c22_hold", c22, EXP_B.c22);
    end
    out_ready = 1'b1;
    wait_in_ready();
    step();
    in_valid = 1'b0;
    wait_out_valid(lat);
    chk("bp_second_latency", lat, 32'd4);
    wait_done();

    // Operand change during MUL is ignored
    sb_q.push_back(EXP_CHG);
    accept(32'h3F800000, 32'h3F000000, 32'h3F800000, 32'h3F800000);
    d1 = 32'h41000000;
    x2 = 32'h40000000;
    round_mode = 3'd3;
    wait_out_valid(lat);
    chk("chg_latency", lat, 32'd4);
    wait_done();
    round_mode = 3'd0;

    // Overflow exceptions, then cleared by the next operation
    run_op("ovf", 32'h7F000000, 32'h3F800000, 32'h7F000000, 32'h3F800000, EXP_OVF);
    run_op("after_ovf", 32'h40000000, 32'h40400000, 32'h40800000, 32'hBF800000, EXP_A);

    // Reset at index 2 abandons the operation; in_valid during reset is ignored
    accept(32'h40000000, 32'h40400000, 32'h40800000, 32'hBF800000);
    step();
    step();
    rst_n = 1'b0;
    in_valid = 1'b1;
    step();
    rst_n = 1'b1;
    in_valid = 1'b0;
    check_idle_zero("midreset");
    for (int i = 0; i < 6; i++) begin
      step();
      chk("midreset_no_valid", {31'd0, out_valid}, 32'd0);
    end

    // Back-to-back with in_valid held high
    sb_q.push_back(EXP_A);
    sb_q.push_back(EXP_B);
    sb_q.push_back(EXP_C);
    set_ops(32'h40000000, 32'h40400000, 32'h40800000, 32'hBF800000);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_in_ready();
      step();
      acc[k] = cyc;
      if (k == 0) set_ops(32'h3FC00000, 32'hC0000000, 32'h40000000, 32'h3F000000);
      else if (k == 1) set_ops(32'hBF800000, 32'h3E800000, 32'h40400000, 32'hC1000000);
      else in_valid = 1'b0;
    end
    chk("b2b_spacing_01", acc[1] - acc[0], 32'd6);
    chk("b2b_spacing_12", acc[2] - acc[1], 32'd6);
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin step(); n++; end
    chk("scoreboard_drained", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/matrix_outer_product_2x1_1x2.md
MATRIX_OUTER_PRODUCT_2X1_1X2 -- requirements
Module: matrix_outer_product_2x1_1x2

Interface
REQ-001 SHALL have parameter exp_width, default 8, exponent field width.
REQ-002 SHALL have parameter mant_width, default 24, mantissa width; word width W = exp_width + mant_width (32 by default).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand set valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have ports d1, d2  input  W each  column vector (2x1), e.g. backprop delta.
REQ-008 SHALL have ports x1, x2  input  W each  row vector (1x2), e.g. layer activation.
REQ-009 SHALL have port round_mode  input  3  rounding mode, same encoding as multiplier.
REQ-010 SHALL have port out_valid  output  1  result matrix valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have ports c11, c12, c21, c22  output  W each  result Cij = di * xj.
REQ-013 SHALL have port exceptions  output  5  bitwise OR of the four multiplier exception vectors.

Function
REQ-014 SHALL compute the 2x2 outer product C = d * x, the inverse-direction counterpart of the 1x2*2x1 dot product, using exactly one shared multiplier instance (exp_width, mant_width passed through).
REQ-015 SHALL implement FSM states IDLE, MUL, DONE; reset state IDLE.
REQ-016 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 SHALL, on an edge with in_valid && in_ready, register d1, d2, x1, x2, round_mode, clear exceptions, clear 2-bit index to 0, enter MUL.
REQ-018 SHALL, in MUL, compute one product per cycle in order index 0:c11=d1*x1, 1:c12=d1*x2, 2:c21=d2*x1, 3:c22=d2*x2, registering the product into the addressed output and OR-ing its exceptions into the exceptions register at each edge.
REQ-019 SHALL move MUL->DONE on the edge that writes index 3; out_valid is therefore high 4 cycles after the accept edge.
REQ-020 SHALL hold c11..c22 and exceptions stable while in DONE and out_ready = 0.
REQ-021 SHALL move DONE->IDLE on an edge with out_valid && out_ready; outputs retain their values after leaving DONE until overwritten.
REQ-022 SHALL ignore in_valid and all operand/round_mode input changes outside IDLE (registered copies used).
REQ-023 SHALL ignore out_ready outside DONE.
REQ-024 SHALL give each product bit-identical to the multiplier for the same operands and round_mode; no additional rounding or normalization.
REQ-025 SHALL achieve a minimum of 6 cycles per operation (accept, 4 MUL, DONE with out_ready = 1); no overlap of operations.

Reset
REQ-026 SHALL, when rst_n = 0 at a clock edge, set state IDLE, index 0, c11..c22 = 0, exceptions = 0, out_valid = 0, in_ready = 1 on the next cycle.
REQ-027 SHALL, on reset mid-MUL or in DONE, abandon the operation with no result delivered; an in_valid asserted during reset is not accepted.

Verification
REQ-028 SHALL cover basic operation: d = (2.0, 3.0) = (40000000, 40400000), x = (4.0, -1.0) = (40800000, BF800000) -> c11 = 41000000, c12 = C0000000, c21 = 41400000, c22 = C0400000, exceptions = 0, out_valid 4 cycles after accept.
REQ-029 SHALL cover backpressure: out_ready held 0 for 10 cycles in DONE -> outputs and out_valid stable, in_ready = 0, a second in_valid is not accepted until after the out handshake.
REQ-030 SHALL cover input change: accept d = (1.0, 0.5), x = (1.0, 1.0), then change d1 to 8.0 during MUL -> c11 = 3F800000, c21 = 3F000000.
REQ-031 SHALL cover exceptions: d1 = x1 = 7F000000, other operands 1.0 -> exceptions equals the multiplier's vector for 7F000000*7F000000 (nonzero); the next accepted operation with normal operands -> exceptions = 0.
REQ-032 SHALL cover reset mid-operation: rst_n = 0 at index 2 -> out_valid never asserts for that operation, all outputs 0, in_ready = 1 the cycle after reset release.
REQ-033 SHALL cover back-to-back operation: in_valid held 1 with out_ready = 1 -> one accept every 6 cycles, results in input order.
